instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Upstream neighbour of the microprogrammed control unit.
- Owns the program counter (pc) and the instruction register (ir).
- Runs a request/valid handshake with instruction memory, captures the returned word into ir, and presents ir[15:11] as the opcode consumed by the control unit's decision state.
- Fetches are started by a control-unit signal; the pc advances when a fetch completes or is reloaded on a jump.

Parameters:
ADDR_WIDTH, 8, width of pc and instruction memory address
WORD_WIDTH, 16, instruction word width (must be >= 16; opcode is ir[15:11])

Ports:
clk  input  1  system clock, all state updates on posedge
rst_n  input  1  synchronous active-low reset, sampled on posedge clk
fetch_start  input  1  control-unit request to fetch the instruction at pc
pc_load  input  1  load pc from load_addr (jump)
load_addr  input  ADDR_WIDTH  jump target
imem_req  output  1  memory read request, registered
imem_addr  output  ADDR_WIDTH  memory read address, registered, stable while imem_req=1
imem_rdata  input  WORD_WIDTH  memory read data, valid when imem_valid=1
imem_valid  input  1  memory response strobe, meaningful only while imem_req=1
ir  output  WORD_WIDTH  instruction register
opcode  output  5  ir[15:11], combinational from ir
ir_valid  output  1  one-cycle pulse: ir was just updated
busy  output  1  state != IDLE
pc  output  ADDR_WIDTH  current program counter

Behaviour:
- Reset, when rst_n=0 at posedge:
  - state=IDLE, pc=0, ir=0, imem_req=0, imem_addr=0, ir_valid=0.
  - Any in-flight fetch is aborted; imem_req is low in the cycle after reset is sampled.
  - An imem_valid arriving after abort is ignored.
- State machine has two states, IDLE and WAIT.
- IDLE, fetch_start=1, pc_load=0: next cycle imem_req=1, imem_addr=pc, state=WAIT.
- IDLE, pc_load=1, fetch_start=0: pc<=load_addr; no request issued.
- IDLE, pc_load=1 and fetch_start=1 together:
  - Jump wins the address: imem_addr=load_addr, pc<=load_addr, state=WAIT.
- WAIT, imem_valid=0: hold imem_req=1 and imem_addr unchanged; pc and ir unchanged.
- WAIT, imem_valid=1:
  - ir<=imem_rdata, pc<=imem_addr+1 (modulo 2^ADDR_WIDTH, so max address wraps to 0).
  - imem_req<=0, ir_valid<=1 for exactly one cycle, state=IDLE.
- fetch_start while in WAIT is ignored; there is no queueing.
- pc_load while in WAIT is ignored. The control unit must only jump while busy=0.
- Latency with zero-wait memory (imem_valid=1 in the first imem_req cycle):
  - fetch_start sampled at edge t.
  - imem_req high during cycle t+1.
  - ir and ir_valid updated at edge t+2.
  - Total 2 cycles from fetch_start to ir_valid.
- Latency with N wait cycles: 2+N.
- ir and opcode hold their old value during WAIT. The control unit may decode the previous instruction concurrently.
- ir_valid and fetch_start in the same cycle: a back-to-back fetch is legal.
  - IDLE accepts the new fetch immediately, giving throughput of one instruction per 2 cycles.
- busy is combinational from state: 1 exactly in WAIT.
- Widths: imem_rdata is captured whole. opcode is always ir[15:11] regardless of WORD_WIDTH.

Test Plan:
- Reset then idle: hold rst_n=0 2 cycles, release -> pc=0, ir=0, opcode=0, imem_req=0, busy=0, ir_valid=0.
- Zero-wait fetch: mem[0]=16'h3A01, pulse fetch_start at t -> imem_req=1 and imem_addr=0 at t+1; ir=16'h3A01, opcode=5'b00111, ir_valid=1 and pc=1 at t+2; ir_valid=0 at t+3.
- Wait states: memory delays imem_valid 3 cycles, mem[1]=16'h4000 -> imem_req and imem_addr=1 stable for 4 cycles; ir=16'h4000, opcode=5'b01000 at t+5; a fetch_start during WAIT produces no extra request.
- Jump and fetch together: pc=5, pc_load=1, load_addr=8'h20 and fetch_start=1 same cycle -> imem_addr=8'h20; after valid, pc=8'h21. pc_load alone in WAIT leaves pc unchanged.
- Wrap-around: pc_load with load_addr=8'hFF, then fetch -> imem_addr=8'hFF, after completion pc=8'h00.
- Reset mid-fetch: fetch issued, memory silent, rst_n=0 for one edge -> imem_req=0 next cycle, state IDLE; a later imem_valid=1 with data 16'hFFFF leaves ir=0 and ir_valid=0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - program counter, instruction register and imem fetch handshake
//
// Ports:
//   clk         system clock, all state updates on posedge
//   rst_n       synchronous active-low reset
//   fetch_start control-unit request to fetch the instruction at pc
//   pc_load     load pc from load_addr (jump); only honoured while idle
//   load_addr   jump target
//   imem_req    registered memory read request
//   imem_addr   registered read address, stable while imem_req=1
//   imem_rdata  memory read data, valid with imem_valid
//   imem_valid  memory response strobe, only looked at while waiting
//   ir          instruction register
//   opcode      ir[15:11]
//   ir_valid    one-cycle pulse after ir is updated
//   busy        high while a fetch is outstanding
//   pc          current program counter
module instr_fetch_unit #(
    parameter int ADDR_WIDTH = 8,
    parameter int WORD_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_start,
    input  logic                  pc_load,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [WORD_WIDTH-1:0] imem_rdata,
    input  logic                  imem_valid,
    output logic [WORD_WIDTH-1:0] ir,
    output logic [4:0]            opcode,
    output logic                  ir_valid,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] pc
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   pc_nxt;
    logic [WORD_WIDTH-1:0]   ir_nxt;
    logic                    imem_req_nxt;
    logic [ADDR_WIDTH-1:0]   imem_addr_nxt;
    logic                    ir_valid_nxt;

    // Reset clears everything, including an outstanding request; since the
    // state returns to IDLE, a late imem_valid from the aborted fetch is
    // never looked at.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= '0;
            ir        <= '0;
            imem_req  <= 1'b0;
            imem_addr <= '0;
            ir_valid  <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            ir        <= ir_nxt;
            imem_req  <= imem_req_nxt;
            imem_addr <= imem_addr_nxt;
            ir_valid  <= ir_valid_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        ir_nxt        = ir;
        imem_req_nxt  = imem_req;
        imem_addr_nxt = imem_addr;
        ir_valid_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (fetch_start) begin
                    // A jump issued together with a fetch supplies the address.
                    imem_req_nxt  = 1'b1;
                    imem_addr_nxt = pc_load ? load_addr : pc;
                    pc_nxt        = pc_load ? load_addr : pc;
                    state_nxt     = WAIT;
                end else if (pc_load) begin
                    pc_nxt = load_addr;
                end
            end
            WAIT: begin
                // fetch_start and pc_load are deliberately ignored here: no queueing.
                if (imem_valid) begin
                    ir_nxt        = imem_rdata;
                    // Natural truncation to ADDR_WIDTH wraps the top address to 0.
                    pc_nxt        = imem_addr + 1'b1;
                    imem_req_nxt  = 1'b0;
                    ir_valid_nxt  = 1'b1;
                    state_nxt     = IDLE;
                end
            end
            default: begin
                state_nxt    = IDLE;
                imem_req_nxt = 1'b0;
            end
        endcase
    end

    assign busy   = (state == WAIT);
    assign opcode = ir[15:11];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_start;
    logic        pc_load;
    logic [7:0]  load_addr;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic [15:0] ir;
    logic [4:0]  opcode;
    logic        ir_valid;
    logic        busy;
    logic [7:0]  pc;

    int n_cmp  = 0;
    int n_fail = 0;

    // Memory responder: answers after mem_delay request cycles unless silenced.
    logic [15:0] mem [0:255];
    int          mem_delay = 0;
    logic        mem_en    = 1'b1;
    logic        force_valid = 1'b0;
    logic [15:0] force_data  = 16'h0000;
    int          req_cnt     = 0;

    assign imem_valid = force_valid | (imem_req & mem_en & (req_cnt >= mem_delay));
    assign imem_rdata = force_valid ? force_data : mem[imem_addr];

    always @(posedge clk) begin
        if (!imem_req || imem_valid) req_cnt <= 0;
        else                         req_cnt <= req_cnt + 1;
    end

    always #5 clk = ~clk;

    instr_fetch_unit #(.ADDR_WIDTH(8), .WORD_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_start(fetch_start), .pc_load(pc_load),
        .load_addr(load_addr), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid), .ir(ir), .opcode(opcode),
        .ir_valid(ir_valid), .busy(busy), .pc(pc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fetch_start = 1'b0; pc_load = 1'b0; load_addr = 8'h00;
        tick(); tick();
        rst_n = 1'b1;
        n_cmp++; if (pc !== 8'h00)      begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc, 8'h00); end
        n_cmp++; if (ir !== 16'h0000)   begin n_fail++; $display("FAIL reset_ir: got %h want %h", ir, 16'h0000); end
        n_cmp++; if (opcode !== 5'd0)   begin n_fail++; $display("FAIL reset_opcode: got %h want %h", opcode, 5'd0); end
        n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
        n_cmp++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ir_valid: got %b want 0", ir_valid); end
        tick();
        n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL idle_req: got %b want 0", imem_req); end
    endtask

    task automatic test_zero_wait();
        mem_delay = 0;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        n_cmp++; if (imem_req !== 1'b1)   begin n_fail++; $display("FAIL zw_req: got %b want 1", imem_req); end
        n_cmp++; if (imem_addr !== 8'h00) begin n_fail++; $display("FAIL zw_addr: got %h want %h", imem_addr, 8'h00); end
        n_cmp++; if (busy !== 1'b1)       begin n_fail++; $display("FAIL zw_busy: got %b want 1", busy); end
        tick();
        n_cmp++; if (ir !== 16'h3A01)     begin n_fail++; $display("FAIL zw_ir: got %h want %h", ir, 16'h3A01); end
        n_cmp++; if (opcode !== 5'b00111) begin n_fail++; $display("FAIL zw_opcode: got %b want %b", opcode, 5'b00111); end
        n_cmp++; if (ir_valid !== 1'b1)   begin n_fail++; $display("FAIL zw_ir_valid: got %b want 1", ir_valid); end
        n_cmp++; if (pc !== 8'h01)        begin n_fail++; $display("FAIL zw_pc: got %h want %h", pc, 8'h01); end
        n_cmp++; if (imem_req !== 1'b0)   begin n_fail++; $display("FAIL zw_req_drop: got %b want 0", imem_req); end
        n_cmp++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL zw_busy_drop: got %b want 0", busy); end
        tick();
        n_cmp++; if (ir_valid !== 1'b0)   begin n_fail++; $display("FAIL zw_pulse: got %b want 0", ir_valid); end
    endtask

    task automatic test_wait_states();
        mem_delay = 3;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            n_cmp++; if (imem_req !== 1'b1)  begin n_fail++; $display("FAIL ws_req_c%0d: got %b want 1", k, imem_req); end
            n_cmp++; if (imem_addr !== 8'h01) begin n_fail++; $display("FAIL ws_addr_c%0d: got %h want %h", k, imem_addr, 8'h01); end
            n_cmp++; if (ir !== 16'h3A01)    begin n_fail++; $display("FAIL ws_ir_hold_c%0d: got %h want %h", k, ir, 16'h3A01); end
            fetch_start = (k == 2);
            tick();
        end
        fetch_start = 1'b0;
        n_cmp++; if (ir !== 16'h4000)     begin n_fail++; $display("FAIL ws_ir: got %h want %h", ir, 16'h4000); end
        n_cmp++; if (opcode !== 5'b01000) begin n_fail++; $display("FAIL ws_opcode: got %b want %b", opcode, 5'b01000); end
        n_cmp++; if (ir_valid !== 1'b1)   begin n_fail++; $display("FAIL ws_ir_valid: got %b want 1", ir_valid); end
        n_cmp++; if (pc !== 8'h02)        begin n_fail++; $display("FAIL ws_pc: got %h want %h", pc, 8'h02); end
        tick();
        n_cmp++; if (imem_req !== 1'b0)   begin n_fail++; $display("FAIL ws_no_extra_req: got %b want 0", imem_req); end
        n_cmp++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL ws_busy: got %b want 0", busy); end
    endtask

    task automatic test_jump_fetch();
        mem_delay = 2;
        pc_load = 1'b1; load_addr = 8'h05;
        tick();
        pc_load = 1'b0;
        n_cmp++; if (pc !== 8'h05)        begin n_fail++; $display("FAIL jmp_pc_load: got %h want %h", pc, 8'h05); end
        n_cmp++; if (imem_req !== 1'b0)   begin n_fail++; $display("FAIL jmp_no_req: got %b want 0", imem_req); end
        pc_load = 1'b1; load_addr = 8'h20; fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        n_cmp++; if (imem_addr !== 8'h20) begin n_fail++; $display("FAIL jmp_addr: got %h want %h", imem_addr, 8'h20); end
        n_cmp++; if (pc !== 8'h20)        begin n_fail++; $display("FAIL jmp_pc: got %h want %h", pc, 8'h20); end
        load_addr = 8'h77;
        tick();
        pc_load = 1'b0;
        n_cmp++; if (pc !== 8'h20)        begin n_fail++; $display("FAIL jmp_load_in_wait: got %h want %h", pc, 8'h20); end
        for (int i = 0; i < 10 && ir_valid !== 1'b1; i++) tick();
        n_cmp++; if (ir_valid !== 1'b1)   begin n_fail++; $display("FAIL jmp_timeout: got ir_valid=%b want 1", ir_valid); end
        n_cmp++; if (ir !== 16'hA5C3)     begin n_fail++; $display("FAIL jmp_ir: got %h want %h", ir, 16'hA5C3); end
        n_cmp++; if (pc !== 8'h21)        begin n_fail++; $display("FAIL jmp_pc_after: got %h want %h", pc, 8'h21); end
        tick();
    endtask

    task automatic test_wrap();
        mem_delay = 0;
        pc_load = 1'b1; load_addr = 8'hFF;
        tick();
        pc_load = 1'b0; fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        n_cmp++; if (imem_addr !== 8'hFF) begin n_fail++; $display("FAIL wrap_addr: got %h want %h", imem_addr, 8'hFF); end
        tick();
        n_cmp++; if (pc !== 8'h00)        begin n_fail++; $display("FAIL wrap_pc: got %h want %h", pc, 8'h00); end
        n_cmp++; if (ir !== 16'h1234)     begin n_fail++; $display("FAIL wrap_ir: got %h want %h", ir, 16'h1234); end
        tick();
    endtask

    task automatic test_back_to_back();
        mem_delay = 0;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        tick();
        n_cmp++; if (ir_valid !== 1'b1)   begin n_fail++; $display("FAIL b2b_first_valid: got %b want 1", ir_valid); end
        n_cmp++; if (ir !== 16'h3A01)     begin n_fail++; $display("FAIL b2b_first_ir: got %h want %h", ir, 16'h3A01); end
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        n_cmp++; if (imem_req !== 1'b1)   begin n_fail++; $display("FAIL b2b_req: got %b want 1", imem_req); end
        n_cmp++; if (imem_addr !== 8'h01) begin n_fail++; $display("FAIL b2b_addr: got %h want %h", imem_addr, 8'h01); end
        tick();
        n_cmp++; if (ir !== 16'h4000)     begin n_fail++; $display("FAIL b2b_second_ir: got %h want %h", ir, 16'h4000); end
        n_cmp++; if (ir_valid !== 1'b1)   begin n_fail++; $display("FAIL b2b_second_valid: got %b want 1", ir_valid); end
        n_cmp++; if (pc !== 8'h02)        begin n_fail++; $display("FAIL b2b_pc: got %h want %h", pc, 8'h02); end
        tick();
    endtask

    task automatic test_reset_mid_fetch();
        mem_en = 1'b0;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        n_cmp++; if (imem_req !== 1'b1)   begin n_fail++; $display("FAIL rmf_req: got %b want 1", imem_req); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_cmp++; if (imem_req !== 1'b0)   begin n_fail++; $display("FAIL rmf_req_abort: got %b want 0", imem_req); end
        n_cmp++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL rmf_busy: got %b want 0", busy); end
        n_cmp++; if (pc !== 8'h00)        begin n_fail++; $display("FAIL rmf_pc: got %h want %h", pc, 8'h00); end
        force_valid = 1'b1; force_data = 16'hFFFF;
        tick();
        force_valid = 1'b0;
        n_cmp++; if (ir !== 16'h0000)     begin n_fail++; $display("FAIL rmf_ir: got %h want %h", ir, 16'h0000); end
        n_cmp++; if (ir_valid !== 1'b0)   begin n_fail++; $display("FAIL rmf_ir_valid: got %b want 0", ir_valid); end
        tick();
        n_cmp++; if (ir_valid !== 1'b0)   begin n_fail++; $display("FAIL rmf_ir_valid_late: got %b want 0", ir_valid); end
        mem_en = 1'b1;
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 16'h0000;
        mem[8'h00] = 16'h3A01;
        mem[8'h01] = 16'h4000;
        mem[8'h20] = 16'hA5C3;
        mem[8'hFF] = 16'h1234;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_jump_fetch();
        test_wrap();
        test_back_to_back();
        test_reset_mid_fetch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
